// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use bubble insertion
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          hold,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_wreg,
    input  logic [3:0]    id_aluctr,
    input  logic [4:0]    id_shamt,
    input  logic          id_alusrc,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic          id_memwrite,
    input  logic          id_memtoreg,
    input  logic          exmem_regwrite,
    input  logic [RW-1:0] exmem_wreg,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_regwrite,
    input  logic [RW-1:0] memwb_wreg,
    input  logic [DW-1:0] memwb_data,
    output logic [DW-1:0] src_a,
    output logic [DW-1:0] src_b,
    output logic [3:0]    aluctr,
    output logic [4:0]    shamt,
    output logic [DW-1:0] store_data,
    output logic          ex_valid,
    output logic [RW-1:0] ex_wreg,
    output logic          ex_regwrite,
    output logic          ex_memread,
    output logic          ex_memwrite,
    output logic          ex_memtoreg,
    output logic          load_use_stall
);

    logic [DW-1:0] rs_data_q;
    logic [DW-1:0] rt_data_q;
    logic [DW-1:0] imm_q;
    logic [RW-1:0] rs_q;
    logic [RW-1:0] rt_q;
    logic          alusrc_q;
    logic          bubble;

    assign load_use_stall = ex_valid && ex_memread && (ex_wreg != '0) && id_valid &&
                            ((ex_wreg == id_rs) || (ex_wreg == id_rt));

    // Hold outranks flush and stall, so a bubble is only written on an unfrozen edge.
    assign bubble = reset || (!hold && (flush || load_use_stall));

    always_ff @(posedge clk) begin
        if (bubble) begin
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            ex_wreg     <= '0;
            aluctr      <= 4'b0000;
            shamt       <= '0;
            alusrc_q    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_valid    <= 1'b0;
        end else if (!hold) begin
            rs_data_q   <= id_rs_data;
            rt_data_q   <= id_rt_data;
            imm_q       <= id_imm;
            rs_q        <= id_rs;
            rt_q        <= id_rt;
            ex_wreg     <= id_wreg;
            aluctr      <= id_aluctr;
            shamt       <= id_shamt;
            alusrc_q    <= id_alusrc   && id_valid;
            ex_regwrite <= id_regwrite && id_valid;
            ex_memread  <= id_memread  && id_valid;
            ex_memwrite <= id_memwrite && id_valid;
            ex_memtoreg <= id_memtoreg && id_valid;
            ex_valid    <= id_valid;
        end
    end

    // Register 0 never matches, so $zero always reads the registered value.
    logic ex_hit_rs, ex_hit_rt, wb_hit_rs, wb_hit_rt;
    logic [DW-1:0] fwd_rs, fwd_rt;

    assign ex_hit_rs = exmem_regwrite && (exmem_wreg != '0) && (exmem_wreg == rs_q);
    assign ex_hit_rt = exmem_regwrite && (exmem_wreg != '0) && (exmem_wreg == rt_q);
    assign wb_hit_rs = memwb_regwrite && (memwb_wreg != '0) && (memwb_wreg == rs_q);
    assign wb_hit_rt = memwb_regwrite && (memwb_wreg != '0) && (memwb_wreg == rt_q);

    assign fwd_rs = ex_hit_rs ? exmem_result : (wb_hit_rs ? memwb_data : rs_data_q);
    assign fwd_rt = ex_hit_rt ? exmem_result : (wb_hit_rt ? memwb_data : rt_data_q);

    assign src_a      = fwd_rs;
    assign store_data = fwd_rt;
    assign src_b      = alusrc_q ? imm_q : fwd_rt;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed and table-driven bench for id_ex_stage
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset, hold, flush, id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_wreg;
    logic [3:0]  id_aluctr;
    logic [4:0]  id_shamt;
    logic        id_alusrc, id_regwrite, id_memread, id_memwrite, id_memtoreg;
    logic        exmem_regwrite;
    logic [4:0]  exmem_wreg;
    logic [31:0] exmem_result;
    logic        memwb_regwrite;
    logic [4:0]  memwb_wreg;
    logic [31:0] memwb_data;
    logic [31:0] src_a, src_b, store_data;
    logic [3:0]  aluctr;
    logic [4:0]  shamt;
    logic        ex_valid;
    logic [4:0]  ex_wreg;
    logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, load_use_stall;

    int errors = 0;
    int checks = 0;

    id_ex_stage #(.DW(32), .RW(5)) dut (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush),
        .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_wreg(id_wreg),
        .id_aluctr(id_aluctr), .id_shamt(id_shamt), .id_alusrc(id_alusrc),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
        .exmem_regwrite(exmem_regwrite), .exmem_wreg(exmem_wreg),
        .exmem_result(exmem_result), .memwb_regwrite(memwb_regwrite),
        .memwb_wreg(memwb_wreg), .memwb_data(memwb_data),
        .src_a(src_a), .src_b(src_b), .aluctr(aluctr), .shamt(shamt),
        .store_data(store_data), .ex_valid(ex_valid), .ex_wreg(ex_wreg),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
        .load_use_stall(load_use_stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        xrw;
        logic [4:0]  xwr;
        logic [31:0] xres;
        logic        mrw;
        logic [4:0]  mwr;
        logic [31:0] mdata;
        logic [31:0] exp_a;
        logic [31:0] exp_rt;
    } fwd_vec_t;

    fwd_vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_rs = 0; id_rt = 0; id_wreg = 0; id_aluctr = 0; id_shamt = 0;
        id_alusrc = 0; id_regwrite = 0; id_memread = 0; id_memwrite = 0; id_memtoreg = 0;
    endtask

    task automatic clear_fwd();
        exmem_regwrite = 0; exmem_wreg = 0; exmem_result = 0;
        memwb_regwrite = 0; memwb_wreg = 0; memwb_data = 0;
    endtask

    initial begin
        reset = 1; hold = 0; flush = 0;
        clear_id();
        clear_fwd();
        step();
        step();
        check("rst_src_a", src_a, 0);
        check("rst_src_b", src_b, 0);
        check("rst_store", store_data, 0);
        check("rst_aluctr", {28'b0, aluctr}, 0);
        check("rst_shamt", {27'b0, shamt}, 0);
        check("rst_valid", {31'b0, ex_valid}, 0);
        check("rst_wreg", {27'b0, ex_wreg}, 0);
        check("rst_ctrl", {28'b0, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg}, 0);
        check("rst_stall", {31'b0, load_use_stall}, 0);

        // Basic capture
        reset = 0;
        id_valid = 1; id_rs_data = 5; id_rt_data = 7; id_rs = 1; id_rt = 2;
        id_wreg = 3; id_regwrite = 1;
        step();
        check("cap_src_a", src_a, 5);
        check("cap_src_b", src_b, 7);
        check("cap_regwrite", {31'b0, ex_regwrite}, 1);
        check("cap_wreg", {27'b0, ex_wreg}, 3);
        check("cap_valid", {31'b0, ex_valid}, 1);

        // Forwarding table against rs=4, rt=6, registered A/B values
        clear_id();
        id_valid = 1; id_rs = 4; id_rt = 6; id_rs_data = 32'hA; id_rt_data = 32'hB;
        id_aluctr = 4'b0010; id_shamt = 5'd3; id_regwrite = 1; id_wreg = 7;
        step();
        check("cap_aluctr", {28'b0, aluctr}, 32'h2);
        check("cap_shamt", {27'b0, shamt}, 32'h3);

        vecs[0] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  32'hA,  32'hB};
        vecs[1] = '{1'b1, 5'd4, 32'h11, 1'b1, 5'd4, 32'h22, 32'h11, 32'hB};
        vecs[2] = '{1'b0, 5'd4, 32'h11, 1'b1, 5'd4, 32'h22, 32'h22, 32'hB};
        vecs[3] = '{1'b1, 5'd6, 32'h33, 1'b1, 5'd6, 32'h44, 32'hA,  32'h33};
        vecs[4] = '{1'b1, 5'd4, 32'h11, 1'b1, 5'd6, 32'h44, 32'h11, 32'h44};
        vecs[5] = '{1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66, 32'hA,  32'hB};
        for (int i = 0; i < 6; i++) begin
            exmem_regwrite = vecs[i].xrw; exmem_wreg = vecs[i].xwr; exmem_result = vecs[i].xres;
            memwb_regwrite = vecs[i].mrw; memwb_wreg = vecs[i].mwr; memwb_data = vecs[i].mdata;
            #1;
            check($sformatf("fwd%0d_src_a", i), src_a, vecs[i].exp_a);
            check($sformatf("fwd%0d_src_b", i), src_b, vecs[i].exp_rt);
            check($sformatf("fwd%0d_store", i), store_data, vecs[i].exp_rt);
        end

        // rs=0 with both stages targeting register 0
        clear_fwd();
        clear_id();
        id_valid = 1; id_rs = 0; id_rs_data = 32'h5A;
        step();
        exmem_regwrite = 1; exmem_wreg = 0; exmem_result = 32'h11;
        memwb_regwrite = 1; memwb_wreg = 0; memwb_data = 32'h22;
        #1;
        check("r0_src_a", src_a, 32'h5A);

        // Immediate select with forwarded rt on store_data
        clear_fwd();
        clear_id();
        id_valid = 1; id_alusrc = 1; id_imm = 32'h0000FFFF; id_rt = 9; id_rt_data = 32'h1;
        id_rs = 2; id_rs_data = 32'h3;
        step();
        exmem_regwrite = 1; exmem_wreg = 9; exmem_result = 32'h99;
        #1;
        check("imm_src_b", src_b, 32'h0000FFFF);
        check("imm_store", store_data, 32'h99);
        check("imm_src_a", src_a, 32'h3);

        // Load-use: lw to r8 in EX, consumer of r8 in ID
        clear_fwd();
        clear_id();
        id_valid = 1; id_memread = 1; id_regwrite = 1; id_memtoreg = 1; id_wreg = 8;
        step();
        clear_id();
        id_valid = 1; id_rs = 1; id_rt = 8; id_regwrite = 1; id_wreg = 10;
        #1;
        check("lu_stall", {31'b0, load_use_stall}, 1);
        step();
        check("lu_bubble_valid", {31'b0, ex_valid}, 0);
        check("lu_bubble_regwrite", {31'b0, ex_regwrite}, 0);
        check("lu_stall_drop", {31'b0, load_use_stall}, 0);
        step();
        check("lu_recap_valid", {31'b0, ex_valid}, 1);
        check("lu_recap_wreg", {27'b0, ex_wreg}, 10);

        // Load-use under hold: register holds, bubble on first unfrozen edge
        clear_id();
        id_valid = 1; id_memread = 1; id_regwrite = 1; id_wreg = 8;
        step();
        clear_id();
        id_valid = 1; id_rs = 8; id_wreg = 11; id_regwrite = 1;
        hold = 1;
        step();
        check("luh_stall", {31'b0, load_use_stall}, 1);
        check("luh_memread", {31'b0, ex_memread}, 1);
        hold = 0;
        step();
        check("luh_bubble", {30'b0, ex_valid, ex_memread}, 0);

        // Hold beats flush; flush bubbles once hold releases
        clear_id();
        id_valid = 1; id_wreg = 5; id_regwrite = 1; id_rs = 3; id_rs_data = 32'h77; id_aluctr = 4'b1111;
        step();
        clear_id();
        id_valid = 1; id_wreg = 12; id_regwrite = 1; id_rs = 3; id_rs_data = 32'h88;
        hold = 1; flush = 1;
        step();
        step();
        check("hold_valid", {31'b0, ex_valid}, 1);
        check("hold_wreg", {27'b0, ex_wreg}, 5);
        check("hold_src_a", src_a, 32'h77);
        check("hold_aluctr", {28'b0, aluctr}, 32'hF);
        hold = 0;
        step();
        check("flush_valid", {31'b0, ex_valid}, 0);
        check("flush_wreg", {27'b0, ex_wreg}, 0);
        check("flush_src_a", src_a, 0);
        check("flush_regwrite", {31'b0, ex_regwrite}, 0);

        // Reset while a store sits in EX
        flush = 0;
        clear_id();
        id_valid = 1; id_memwrite = 1; id_rt = 4; id_rt_data = 32'h1234;
        step();
        check("st_memwrite", {31'b0, ex_memwrite}, 1);
        check("st_store", store_data, 32'h1234);
        reset = 1;
        step();
        check("rstmid_memwrite", {31'b0, ex_memwrite}, 0);
        check("rstmid_valid", {31'b0, ex_valid}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register with operand forwarding for the 5-stage MIPS core. Sits directly upstream of the ALU: captures decoded operands and control from ID, then drives the ALU's srcA/srcB/aluctr/shamt from registered state plus EX/MEM and MEM/WB forwarding. Also detects load-use hazards and inserts bubbles. Handles global hold and branch flush.

Parameters:
DW, 32, datapath width
RW, 5, register-address width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
hold  in  1  global pipeline freeze (e.g. memory wait)
flush  in  1  squash the instruction entering EX (branch/jump taken)
id_valid  in  1  ID slot holds a real instruction
id_rs_data  in  DW  register-file read A
id_rt_data  in  DW  register-file read B
id_imm  in  DW  immediate, already extended by ID
id_rs  in  RW  source register A address
id_rt  in  RW  source register B address
id_wreg  in  RW  destination address, already selected by ID
id_aluctr  in  4  ALU opcode, ALU encoding (ADD=0000 ... XORI=1111)
id_shamt  in  5  shift amount
id_alusrc  in  1  1 selects immediate for srcB
id_regwrite  in  1  writes register file
id_memread  in  1  load
id_memwrite  in  1  store
id_memtoreg  in  1  WB selects memory data
exmem_regwrite  in  1  EX/MEM writes register
exmem_wreg  in  RW  EX/MEM destination
exmem_result  in  DW  EX/MEM ALU result
memwb_regwrite  in  1  MEM/WB writes register
memwb_wreg  in  RW  MEM/WB destination
memwb_data  in  DW  MEM/WB writeback value
src_a  out  DW  ALU srcA
src_b  out  DW  ALU srcB
aluctr  out  4  registered ALU opcode
shamt  out  5  registered shift amount
store_data  out  DW  forwarded rt value for stores
ex_valid  out  1  EX slot holds a real instruction
ex_wreg, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  out  RW/1/1/1/1  registered control to EX/MEM
load_use_stall  out  1  request to freeze IF/ID one cycle

Behaviour:
- All registered fields (data, addresses, control, valid) update on the rising clk edge. Capture latency is 1 cycle: ID values at edge N are visible at outputs after edge N.
- Per-edge priority: reset > hold > flush > load_use_stall > capture.
  - reset: ex_valid=0, all control 0, addresses 0, data 0, aluctr=0000 (ADD), shamt=0.
  - hold: every register keeps its value.
  - flush or load_use_stall: load a bubble, i.e. same values as reset.
  - capture: all id_* values load. ex_valid=id_valid. Control bits are gated by id_valid (invalid instruction, so control 0).
- Bubble guarantees no register-file write, memory access or stall request from the EX slot.
- load_use_stall (combinational): ex_valid & ex_memread & ex_wreg!=0 & id_valid & (ex_wreg==id_rs | ex_wreg==id_rt).
  - Asserted with hold=1: the ID/EX register holds. The bubble is inserted on the first edge with hold=0.
- Forwarding (combinational, independently for rs and rt):
  - EX/MEM match (exmem_regwrite & exmem_wreg!=0 & exmem_wreg==reg): use exmem_result.
  - Else MEM/WB match under the same rule: use memwb_data.
  - Else the registered register-file value.
  - EX/MEM has priority when both match. Register 0 is never forwarded, so src reads the registered value (0 from regfile).
- src_a = forwarded rs. store_data = forwarded rt. src_b = ex_alusrc ? registered imm : forwarded rt.
- Forwarding uses the current-cycle exmem_*/memwb_* inputs, not registered copies. With hold=1, forwarded outputs still track inputs.
- No arithmetic is performed here. Widths pass through unchanged.

Test Plan:
- Reset then capture: reset 2 cycles, check all outputs 0 and aluctr=0000. Then drive id_valid=1, rs_data=5, rt_data=7, aluctr=0000, alusrc=0, regwrite=1, wreg=3 -> next cycle src_a=5, src_b=7, ex_regwrite=1, ex_wreg=3, ex_valid=1.
- Forwarding priority: EX rs=4, both exmem_wreg=4 (result 0x11) and memwb_wreg=4 (data 0x22) writing -> src_a=0x11. Deassert exmem_regwrite -> src_a=0x22. Set rs=0 with both matching 0 -> src_a=registered value.
- Immediate select: alusrc=1, imm=0x0000FFFF, rt forwarded 0x99 -> src_b=0x0000FFFF, store_data=0x99.
- Load-use: EX holds lw to wreg=8 (memread=1); ID id_rt=8, id_valid=1 -> load_use_stall=1. Next edge loads a bubble (ex_valid=0, ex_regwrite=0) and load_use_stall drops.
- Hold vs flush: hold=1 and flush=1 together for 2 cycles -> all registered outputs unchanged. Release hold with flush=1 -> bubble loaded.
- Reset mid-operation: assert reset while a valid store (memwrite=1) occupies EX -> after the edge ex_memwrite=0 and ex_valid=0.
